// File: rtl/difftest_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_pkg
//  Purpose  : Shared types and constants for the difftest commit queue.
//  Revision : 1.0 - initial release
// ============================================================================
package difftest_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NR_GPR   = 33;
    localparam int NPC_IDX  = 32;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [31:0]         inst;
        logic                wen;
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] wdata;
        logic [XLEN_DEF-1:0] npc;
    } commit_rec_t;

endpackage
`default_nettype wire

// File: rtl/difftest_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_fifo
//  Purpose  : Synchronous FIFO of commit records with wrap-bit pointers.
//  Revision : 1.0 - initial release
// ============================================================================
module difftest_fifo
    import difftest_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  commit_rec_t wr_rec,
    output commit_rec_t rd_rec,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    commit_rec_t r_mem [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) r_mem[r_wr_ptr[AW-1:0]] <= wr_rec;
    end

    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign rd_rec = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/difftest_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_commit_queue
//  Purpose  : Buffers retired-instruction records and applies them to a
//             shadow GPR/next-PC file as the difftest checker consumes them.
//  Revision : 1.0 - initial release
// ============================================================================
module difftest_commit_queue
    import difftest_pkg::*;
#(
    parameter int               DEPTH    = 8,
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cmt_valid,
    output logic                   cmt_ready,
    input  logic [XLEN-1:0]        cmt_pc,
    input  logic [31:0]            cmt_inst,
    input  logic                   cmt_wen,
    input  logic [4:0]             cmt_rd,
    input  logic [XLEN-1:0]        cmt_wdata,
    input  logic [XLEN-1:0]        cmt_npc,
    output logic                   dt_valid,
    input  logic                   dt_ready,
    output logic                   chk_pulse,
    output logic [XLEN-1:0]        chk_pc,
    output logic [31:0]            chk_inst,
    output logic [NR_GPR*XLEN-1:0] gpr_flat,
    output logic [63:0]            instret,
    output logic                   ovf_err
);

    commit_rec_t w_wr_rec;
    commit_rec_t w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;

    logic [XLEN-1:0] r_gpr [NR_GPR];
    logic            r_chk_pulse;
    logic [XLEN-1:0] r_chk_pc;
    logic [31:0]     r_chk_inst;
    logic [63:0]     r_instret;
    logic            r_ovf_err;

    always_comb begin
        w_wr_rec       = '0;
        w_wr_rec.pc    = cmt_pc;
        w_wr_rec.inst  = cmt_inst;
        w_wr_rec.wen   = cmt_wen;
        w_wr_rec.rd    = cmt_rd;
        w_wr_rec.wdata = cmt_wdata;
        w_wr_rec.npc   = cmt_npc;
    end

    // Ready depends only on occupancy, so a pop never frees a slot in the same cycle.
    assign w_push    = cmt_valid && !w_full;
    assign w_pop     = dt_ready && !w_empty;
    assign cmt_ready = !w_full;
    assign dt_valid  = !w_empty;

    difftest_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .wr_rec  (w_wr_rec),
        .rd_rec  (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NR_GPR; i++) begin
                r_gpr[i] <= (i == NPC_IDX) ? RESET_PC : '0;
            end
        end else if (w_pop) begin
            if (w_head.wen && (w_head.rd != 5'd0)) begin
                r_gpr[w_head.rd] <= w_head.wdata;
            end
            r_gpr[NPC_IDX] <= w_head.npc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chk_pulse <= 1'b0;
            r_chk_pc    <= '0;
            r_chk_inst  <= '0;
            r_instret   <= '0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_chk_pulse <= w_pop;
            if (w_pop) begin
                r_chk_pc   <= w_head.pc;
                r_chk_inst <= w_head.inst;
                r_instret  <= r_instret + 64'd1;
            end
            if (cmt_valid && w_full) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NR_GPR; g++) begin : g_flat
            assign gpr_flat[g*XLEN +: XLEN] = r_gpr[g];
        end
    endgenerate

    assign chk_pulse = r_chk_pulse;
    assign chk_pc    = r_chk_pc;
    assign chk_inst  = r_chk_inst;
    assign instret   = r_instret;
    assign ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_difftest_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_difftest_commit_queue
//  Purpose  : Randomized scoreboard bench for difftest_commit_queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_difftest_commit_queue;

    localparam int          DEPTH    = 8;
    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic [63:0] npc;
    } tb_rec_t;

    logic             clock;
    logic             reset_n;
    logic             cmt_valid;
    logic             cmt_ready;
    logic [63:0]      cmt_pc;
    logic [31:0]      cmt_inst;
    logic             cmt_wen;
    logic [4:0]       cmt_rd;
    logic [63:0]      cmt_wdata;
    logic [63:0]      cmt_npc;
    logic             dt_valid;
    logic             dt_ready;
    logic             chk_pulse;
    logic [63:0]      chk_pc;
    logic [31:0]      chk_inst;
    logic [33*64-1:0] gpr_flat;
    logic [63:0]      instret;
    logic             ovf_err;

    difftest_commit_queue #(
        .DEPTH    (DEPTH),
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmt_valid (cmt_valid),
        .cmt_ready (cmt_ready),
        .cmt_pc    (cmt_pc),
        .cmt_inst  (cmt_inst),
        .cmt_wen   (cmt_wen),
        .cmt_rd    (cmt_rd),
        .cmt_wdata (cmt_wdata),
        .cmt_npc   (cmt_npc),
        .dt_valid  (dt_valid),
        .dt_ready  (dt_ready),
        .chk_pulse (chk_pulse),
        .chk_pc    (chk_pc),
        .chk_inst  (chk_inst),
        .gpr_flat  (gpr_flat),
        .instret   (instret),
        .ovf_err   (ovf_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    tb_rec_t     sb [$];
    int          occ;
    logic        exp_ovf;
    logic [63:0] m_gpr [33];
    logic [63:0] m_instret;
    tb_rec_t     mon_rec;
    tb_rec_t     idle_rec;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_gpr_all(input string tag);
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("%s_gpr%0d", tag, i), gpr_flat[i*64 +: 64], m_gpr[i]);
        end
    endtask

    function automatic tb_rec_t rnd_rec();
        tb_rec_t r;
        r.pc    = {$urandom, $urandom};
        r.inst  = $urandom;
        r.wen   = ($urandom_range(0, 3) != 0);
        r.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        r.wdata = {$urandom, $urandom};
        r.npc   = {$urandom, $urandom};
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, check handshake outputs
    // against the occupancy model just before the rising edge, then update it.
    task automatic cycle(input logic v, input tb_rec_t r, input logic rdy);
        logic do_push;
        logic do_pop;
        @(negedge clock);
        cmt_valid = v;
        cmt_pc    = r.pc;
        cmt_inst  = r.inst;
        cmt_wen   = r.wen;
        cmt_rd    = r.rd;
        cmt_wdata = r.wdata;
        cmt_npc   = r.npc;
        dt_ready  = rdy;
        #4;
        chk("cmt_ready", cmt_ready, (occ < DEPTH));
        chk("dt_valid", dt_valid, (occ != 0));
        chk("ovf_err", ovf_err, exp_ovf);
        do_push = v && (occ < DEPTH);
        do_pop  = rdy && (occ != 0);
        if (v && !(occ < DEPTH)) exp_ovf = 1'b1;
        if (do_push) sb.push_back(r);
        occ = occ + int'(do_push) - int'(do_pop);
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset_n   = 1'b0;
        cmt_valid = 1'b0;
        dt_ready  = 1'b0;
        sb.delete();
        occ       = 0;
        exp_ovf   = 1'b0;
        m_instret = '0;
        for (int i = 0; i < 33; i++) m_gpr[i] = (i == 32) ? RESET_PC : 64'd0;
        #1;
        chk("rst_dt_valid", dt_valid, 1'b0);
        chk("rst_cmt_ready", cmt_ready, 1'b1);
        chk("rst_ovf_err", ovf_err, 1'b0);
        chk("rst_chk_pulse", chk_pulse, 1'b0);
        chk("rst_chk_pc", chk_pc, 64'd0);
        chk("rst_chk_inst", chk_inst, 64'd0);
        chk("rst_instret", instret, m_instret);
        chk_gpr_all("rst");
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: each checker strobe consumes the oldest expected record.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && chk_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_chk_pulse: got=1 expected=0");
            end else begin
                mon_rec = sb.pop_front();
                if (mon_rec.wen && mon_rec.rd != 5'd0) m_gpr[mon_rec.rd] = mon_rec.wdata;
                m_gpr[32] = mon_rec.npc;
                m_instret = m_instret + 64'd1;
                chk("chk_pc", chk_pc, mon_rec.pc);
                chk("chk_inst", chk_inst, 64'(mon_rec.inst));
                chk("instret", instret, m_instret);
                chk_gpr_all("mon");
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tb_rec_t r;
        reset_n   = 1'b0;
        cmt_valid = 1'b0;
        dt_ready  = 1'b0;
        idle_rec  = '0;
        {cmt_pc, cmt_inst, cmt_wen, cmt_rd, cmt_wdata, cmt_npc} = '0;
        occ       = 0;
        exp_ovf   = 1'b0;

        do_reset();

        // Single record: latency and register write.
        r = '{pc: 64'h8000_0000, inst: 32'h0000_0293, wen: 1'b1, rd: 5'd5,
              wdata: 64'h1234, npc: 64'h8000_0004};
        cycle(1'b1, r, 1'b1);
        #1;
        chk("lat_pulse_n1", chk_pulse, 1'b0);
        chk("lat_dt_valid_n1", dt_valid, 1'b1);
        cycle(1'b0, idle_rec, 1'b1);
        #1;
        chk("lat_pulse_n2", chk_pulse, 1'b1);
        chk("t2_gpr5", gpr_flat[5*64 +: 64], 64'h1234);
        chk("t2_npc", gpr_flat[32*64 +: 64], 64'h8000_0004);
        chk("t2_instret", instret, 64'd1);

        // Write to x0 is dropped but npc still applies.
        r = '{pc: 64'h8000_0004, inst: 32'h0000_0013, wen: 1'b1, rd: 5'd0,
              wdata: 64'hFFFF, npc: 64'h8000_0008};
        cycle(1'b1, r, 1'b1);
        cycle(1'b0, idle_rec, 1'b1);
        #1;
        chk("t3_gpr0", gpr_flat[63:0], 64'd0);
        chk("t3_npc", gpr_flat[32*64 +: 64], 64'h8000_0008);
        chk("t3_instret", instret, 64'd2);

        // Fill to full with the checker stalled, overflow once, then drain.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd_rec(), 1'b0);
        cycle(1'b1, rnd_rec(), 1'b0);
        cycle(1'b0, idle_rec, 1'b0);
        #1;
        chk("t4_full_ready", cmt_ready, 1'b0);
        chk("t4_ovf", ovf_err, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, idle_rec, 1'b1);
        #1;
        chk("t4_ovf_sticky", ovf_err, 1'b1);

        // Streaming push+pop every cycle, wrapping the pointers several times.
        for (int i = 0; i < 3 * DEPTH; i++) cycle(1'b1, rnd_rec(), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, idle_rec, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 99) < 60), rnd_rec(), ($urandom_range(0, 99) < 50));
        end

        // Reset with records in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_rec(), 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, idle_rec, 1'b1);

        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 99) < 50), rnd_rec(), ($urandom_range(0, 99) < 60));
        end

        // Bounded drain, then every expected record must have been applied.
        for (int i = 0; i < 4 * DEPTH && occ != 0; i++) cycle(1'b0, idle_rec, 1'b1);
        cycle(1'b0, idle_rec, 1'b1);
        cycle(1'b0, idle_rec, 1'b1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
